alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, width-parametrised ALU for the MIPS datapath. It keeps the single-cycle operations already used by the core (add, sub, lui) and adds and, or, nor, slt and shifts. It also adds iterative unsigned multiply and divide, with a start/busy/done handshake and a HI/LO result pair. It sits in the execute stage. The control unit issues `start_i` and stalls on `busy_o`.

## Interface
- `DATA_WIDTH`, 32: operand and result width; even, ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request; accepted only in IDLE.
- `alu_operation_i`  in  4  op code, sampled on accepted start.
- `a_i`  in  DATA_WIDTH  operand A (rs), sampled on accepted start.
- `b_i`  in  DATA_WIDTH  operand B (rt/imm), sampled on accepted start.
- `busy_o`  out  1  high from the cycle after accept until the cycle after done.
- `done_o`  out  1  one-cycle pulse; results valid in that cycle and held afterwards.
- `alu_data_o`  out  DATA_WIDTH  result (LO for mult, quotient for div).
- `hi_o`  out  DATA_WIDTH  mult upper half or div remainder; 0 for other ops.
- `zero_o`  out  1  `alu_data_o == 0`, registered with it.

## Operation
- Op codes:
  - ADD 0011: a+b, wraps mod 2^W.
  - SUB 0001: a−b, wraps.
  - LUI 0100: b[W/2−1:0] shifted to the upper half, lower half 0.
  - AND 0101, OR 0110, NOR 0111: bitwise.
  - SLT 1000: signed a<b gives 1, else 0.
  - SLL 1001, SRL 1010: a shifted by b[log2(W)−1:0].
  - MULTU 1011: unsigned product, width 2W.
  - DIVU 1100: unsigned quotient and remainder.
  - Any other code: result 0.
- FSM states IDLE, RUN, DONE.
  - IDLE with start_i and an iterative op → RUN. Iteration counter loads W−1.
  - IDLE with start_i and any other op → DONE. The result is registered on the accept edge.
  - RUN → DONE when the counter reaches 0; otherwise the counter decrements.
  - DONE → IDLE unconditionally.
- MULTU is shift-add, one bit per cycle: {hi,lo} accumulates, multiplier LSB first.
- DIVU is restoring shift-subtract, one bit per cycle, quotient MSB first.
- Divide by zero: quotient all ones, remainder = a. No error flag.
- `start_i` in RUN or DONE is ignored. It is neither queued nor lost silently; the issuer must hold or retry.
- Operands are latched at accept, so input changes during RUN have no effect.
- `alu_data_o`, `hi_o` and `zero_o` hold their value until the next accepted operation completes.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state → IDLE.
  - `busy_o`, `done_o` = 0; `alu_data_o`, `hi_o` = 0; `zero_o` = 1.
  - Partial results are discarded.
- Single-cycle op accepted at edge t: `done_o` high for the cycle after t. `busy_o` stays 0.
- Iterative op accepted at edge t: `busy_o` high cycles t+1 .. t+W+1. `done_o` high only in cycle t+W+1. Total latency is W+1 cycles.
- Back-to-back: the next start is accepted at the first edge where state is IDLE. For single-cycle ops that is every second cycle.

## Configuration
- `ALU_MC_DIV_EN` defined:
  - DIVU datapath compiled in, as specified above.
- Undefined:
  - No divider logic.
  - DIVU behaves as an unknown op: single-cycle, result 0, `hi_o` 0, `zero_o` 1.
  - MULTU is unaffected.

## Structure
- Package `alu_mc_pkg`:
  - op code localparams (ADD, SUB, LUI, AND, OR, NOR, SLT, SLL, SRL, MULTU, DIVU).
  - FSM state encodings.
  - A function returning log2(DATA_WIDTH) for the counter width.
- Sub-module `alu_mc_iter`: W-iteration shift-add/shift-subtract datapath (acc, operand and counter registers), with `load`, `mode` and `last` signals.
- `alu_mc` holds the FSM, the combinational single-cycle ops and the output registers.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1 → `done_o` next cycle, `alu_data_o`=0x80000000, `zero_o`=0, `busy_o` never high.
- SUB a=5, b=5 → `alu_data_o`=0, `zero_o`=1. LUI b=0x00001234 → 0x12340000. SLT a=0xFFFFFFFF, b=1 → 1.
- MULTU a=0xFFFFFFFF, b=2 → `done_o` exactly 33 cycles after accept; `hi_o`=1, `alu_data_o`=0xFFFFFFFE. A start pulse mid-RUN is ignored.
- DIVU a=100, b=7 → quotient 14, `hi_o`=2. DIVU a=9, b=0 → 0xFFFFFFFF, `hi_o`=9. Without `ALU_MC_DIV_EN`: 0, `hi_o`=0, latency 1.
- Reset asserted at cycle 10 of a MULTU → all outputs at reset values immediately. The next ADD 2+3 completes normally with result 5.
- DATA_WIDTH=8: MULTU 0xFF×0xFF → `hi_o`=0xFE, `alu_data_o`=0x01, latency 9 cycles.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: op codes, FSM state encoding and a log2 helper for the
// multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_LUI   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Ceiling log2; sizes the iteration counter and the shift amount field.
  function automatic int alu_log2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one-bit-per-cycle shift-add multiplier and (when
// ALU_MC_DIV_EN is defined) restoring divider sharing one accumulator.
// mode = 0 multiplies, mode = 1 divides. acc ends as HI / remainder,
// aux ends as LO / quotient. *_nxt expose the value the next step writes
// so the caller can capture the final result on the last step.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  en,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] acc_nxt,
  output logic [DATA_WIDTH-1:0] aux_nxt
);

  localparam int CW = alu_log2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] aux_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [CW-1:0]         cnt_q;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_acc;
  logic [DATA_WIDTH-1:0] mul_aux;

  // Multiply step: add multiplicand when multiplier LSB is set, then shift
  // the {acc, aux} pair right so the product builds up from the LSB.
  assign mul_sum = {1'b0, acc_q} + (aux_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = mul_sum[DATA_WIDTH:1];
  assign mul_aux = {mul_sum[0], aux_q[DATA_WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  logic [DATA_WIDTH:0] div_shift;
  logic [DATA_WIDTH:0] div_diff;

  // Divide step: shift next dividend bit into the remainder and subtract
  // the divisor; a zero divisor always "fits", giving all-ones quotient
  // and the dividend as remainder without special casing.
  assign div_shift = {acc_q, aux_q[DATA_WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // Select the step result for the active mode.
  always_comb begin
    acc_nxt = mul_acc;
    aux_nxt = mul_aux;
    if (mode) begin
      if (!div_diff[DATA_WIDTH]) begin
        acc_nxt = div_diff[DATA_WIDTH-1:0];
        aux_nxt = {aux_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift[DATA_WIDTH-1:0];
        aux_nxt = {aux_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign acc_nxt     = mul_acc;
  assign aux_nxt     = mul_aux;
`endif

  assign last = (cnt_q == '0);

  // Iteration counter: loads W-1 on accept and counts down once per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(DATA_WIDTH - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Datapath registers: operands latched on accept, stepped while running.
  always_ff @(posedge clk) begin
    if (load) begin
      acc_q  <= '0;
      aux_q  <= a;
      opnd_q <= b;
    end else if (en) begin
      acc_q <= acc_nxt;
      aux_q <= aux_nxt;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS execute-stage ALU. Single-cycle ops complete in
// one cycle; MULTU (and DIVU when ALU_MC_DIV_EN is defined) iterate for
// DATA_WIDTH cycles behind a start/busy/done handshake. Without
// ALU_MC_DIV_EN, DIVU is treated like an unknown op (result 0).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] alu_data_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic                  zero_o
);

  localparam int SW = alu_log2(DATA_WIDTH);

  alu_state_e state_q;
  alu_state_e state_d;

  logic                  accept;
  logic                  op_iter;
  logic                  iter_q;
  logic                  mode_q;
  logic                  it_load;
  logic                  it_en;
  logic                  it_last;
  logic [DATA_WIDTH-1:0] it_acc_nxt;
  logic [DATA_WIDTH-1:0] it_aux_nxt;

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic [DATA_WIDTH-1:0]        sc_res;

  logic [DATA_WIDTH-1:0] alu_data_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic                  zero_q;

  assign accept = (state_q == ST_IDLE) && start_i;

`ifdef ALU_MC_DIV_EN
  assign op_iter = (alu_operation_i == OP_MULTU) || (alu_operation_i == OP_DIVU);
`else
  assign op_iter = (alu_operation_i == OP_MULTU);
`endif

  assign a_s = a_i;
  assign b_s = b_i;

  // Single-cycle results, evaluated on the live inputs at the accept edge.
  always_comb begin
    sc_res = '0;
    case (alu_operation_i)
      OP_ADD: sc_res = a_i + b_i;
      OP_SUB: sc_res = a_i - b_i;
      OP_LUI: sc_res = {b_i[DATA_WIDTH/2-1:0], {(DATA_WIDTH/2){1'b0}}};
      OP_AND: sc_res = a_i & b_i;
      OP_OR:  sc_res = a_i | b_i;
      OP_NOR: sc_res = ~(a_i | b_i);
      OP_SLT: sc_res = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLL: sc_res = a_i << b_i[SW-1:0];
      OP_SRL: sc_res = a_i >> b_i[SW-1:0];
      default: sc_res = '0;
    endcase
  end

  // FSM next state plus handshake and iterator controls.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    it_load = accept && op_iter;
    it_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = op_iter ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        it_en  = 1'b1;
        if (it_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        busy_o  = iter_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus op-type flags latched at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      iter_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        iter_q <= op_iter;
        mode_q <= (alu_operation_i == OP_DIVU);
      end
    end
  end

  alu_mc_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (it_load),
    .en      (it_en),
    .mode    (mode_q),
    .a       (a_i),
    .b       (b_i),
    .last    (it_last),
    .acc_nxt (it_acc_nxt),
    .aux_nxt (it_aux_nxt)
  );

  // Result registers: written on a single-cycle accept or on the final
  // iteration step, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_data_q <= '0;
      hi_q       <= '0;
      zero_q     <= 1'b1;
    end else if (accept && !op_iter) begin
      alu_data_q <= sc_res;
      hi_q       <= '0;
      zero_q     <= (sc_res == '0);
    end else if ((state_q == ST_RUN) && it_last) begin
      alu_data_q <= it_aux_nxt;
      hi_q       <= it_acc_nxt;
      zero_q     <= (it_aux_nxt == '0);
    end
  end

  assign alu_data_o = alu_data_q;
  assign hi_o       = hi_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc at DATA_WIDTH 32 and 8.
// DIVU expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start32, busy32, done32, zero32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, data32, hi32;

  logic        start8, busy8, done8, zero8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, data8, hi8;

  alu_mc #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .start_i(start32), .alu_operation_i(op32),
    .a_i(a32), .b_i(b32), .busy_o(busy32), .done_o(done32),
    .alu_data_o(data32), .hi_o(hi32), .zero_o(zero32)
  );

  alu_mc #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start_i(start8), .alu_operation_i(op8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
    .alu_data_o(data8), .hi_o(hi8), .zero_o(zero8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Issue one op on the 32-bit ALU and check latency, results and busy.
  // poke > 0 raises a stray ADD start in that cycle after accept.
  task automatic run32(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_lo,
                       input logic [31:0] exp_hi, input int poke);
    int lat;
    int bcnt;
    @(posedge clk); #1;
    check({tag, "/idle_done"}, 32'(done32), 32'd0);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = '1; b32 = '1;
    lat = 1; bcnt = 0;
    while (!done32 && lat < 200) begin
      if (busy32) bcnt++;
      start32 = (lat == poke);
      if (lat == poke) op32 = OP_ADD;
      @(posedge clk); #1;
      lat++;
    end
    start32 = 1'b0;
    if (busy32) bcnt++;
    check({tag, "/lat"},  lat,           exp_lat);
    check({tag, "/lo"},   data32,        exp_lo);
    check({tag, "/hi"},   hi32,          exp_hi);
    check({tag, "/zero"}, 32'(zero32),   32'(exp_lo == 32'd0));
    check({tag, "/busy"}, bcnt,          (exp_lat > 1) ? exp_lat : 0);
  endtask

  task automatic run8(input string tag, input logic [3:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input int exp_lat, input logic [7:0] exp_lo,
                      input logic [7:0] exp_hi);
    int lat;
    @(posedge clk); #1;
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = '1; b8 = '1;
    lat = 1;
    while (!done8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, lat,         exp_lat);
    check({tag, "/lo"},  32'(data8),  32'(exp_lo));
    check({tag, "/hi"},  32'(hi8),    32'(exp_hi));
  endtask

  initial begin
    rst_n = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst/data", data32, 32'd0);
    check("rst/hi",   hi32,   32'd0);
    check("rst/zero", 32'(zero32), 32'd1);
    check("rst/busy", 32'(busy32), 32'd0);
    check("rst/done", 32'(done32), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run32("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 32'h0, 0);
    run32("sub_eq",  OP_SUB, 32'd5, 32'd5, 1, 32'h0, 32'h0, 0);
    run32("lui",     OP_LUI, 32'h0000DEAD, 32'h00001234, 1, 32'h12340000, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold/data", data32, 32'h12340000);
    check("hold/done", 32'(done32), 32'd0);
    run32("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 32'h0, 0);
    run32("slt_pos", OP_SLT, 32'h1, 32'hFFFFFFFF, 1, 32'h0, 32'h0, 0);
    run32("and", OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h00F000F0, 32'h0, 0);
    run32("or",  OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFFF0FFF0, 32'h0, 0);
    run32("nor", OP_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h000F000F, 32'h0, 0);
    run32("sll", OP_SLL, 32'h1, 32'hFFFFFFE4, 1, 32'h00000010, 32'h0, 0);
    run32("srl", OP_SRL, 32'h80000000, 32'd31, 1, 32'h1, 32'h0, 0);
    run32("badop", 4'b1111, 32'd5, 32'd6, 1, 32'h0, 32'h0, 0);

    run32("mul_ff2", OP_MULTU, 32'hFFFFFFFF, 32'h2, 33, 32'hFFFFFFFE, 32'h1, 5);
    run32("add_after_mul", OP_ADD, 32'h1, 32'h1, 1, 32'h2, 32'h0, 0);
    run32("mul_2p32", OP_MULTU, 32'h00010000, 32'h00010000, 33, 32'h0, 32'h1, 0);

`ifdef ALU_MC_DIV_EN
    run32("div_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 0);
    run32("div_by0",   OP_DIVU, 32'd9, 32'd0, 33, 32'hFFFFFFFF, 32'd9, 0);
    run32("div_big",   OP_DIVU, 32'hFFFFFFFF, 32'h10, 33, 32'h0FFFFFFF, 32'hF, 0);
`else
    run32("div_100_7", OP_DIVU, 32'd100, 32'd7, 1, 32'h0, 32'h0, 0);
    run32("div_by0",   OP_DIVU, 32'd9, 32'd0, 1, 32'h0, 32'h0, 0);
`endif

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    start32 = 1'b1; op32 = OP_MULTU; a32 = 32'h1234; b32 = 32'h5678;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("midrst/busy_before", 32'(busy32), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst/data", data32, 32'd0);
    check("midrst/hi",   hi32,   32'd0);
    check("midrst/zero", 32'(zero32), 32'd1);
    check("midrst/busy", 32'(busy32), 32'd0);
    check("midrst/done", 32'(done32), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run32("add_after_rst", OP_ADD, 32'd2, 32'd3, 1, 32'd5, 32'h0, 0);

    run8("w8_mul", OP_MULTU, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE);
`ifdef ALU_MC_DIV_EN
    run8("w8_div", OP_DIVU, 8'hFF, 8'h10, 9, 8'h0F, 8'h0F);
`else
    run8("w8_div", OP_DIVU, 8'hFF, 8'h10, 1, 8'h00, 8'h00);
`endif
    run8("w8_add", OP_ADD, 8'hFF, 8'h02, 1, 8'h01, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
